// File: rtl/tx_pack_pkg.sv
// Shared helpers for the USB transmit word packer: ratio legality,
// constant clog2 and the lane-order mapping.
package tx_pack_pkg;

  // Status pulses raised by the packer, registered together.
  typedef struct packed {
    logic trunc;
    logic partial;
    logic overflow;
  } pack_events_t;

  // Ceiling log2 usable in constant expressions.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result = result + 1;
    return result;
  endfunction

  // Narrow words per wide word must stay within 2..8.
  function automatic bit ratio_legal(input int ratio);
    return (ratio >= 2) && (ratio <= 8);
  endfunction

  // Width of a counter that runs 0..ratio-1 (never narrower than 1 bit).
  function automatic int lane_bits(input int ratio);
    return (clog2(ratio) < 1) ? 1 : clog2(ratio);
  endfunction

  // Physical lane that the lane-th word of a group lands in.
  function automatic int lane_index(input int lane, input int ratio, input bit msb_first);
    return msb_first ? (ratio - 1 - lane) : lane;
  endfunction

endpackage

// File: rtl/tx_pack_fifo2.sv
// Two-entry synchronous FIFO with push/pop/full/empty. Generic enough to be
// reused on the receive side.
module tx_pack_fifo2 #(
  parameter int WIDTH = 32
) (
  input  logic             usbclk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count;
  logic             do_push;
  logic             do_pop;

  // Pop only when something is held; a push into a full FIFO is taken only
  // when the head leaves in the same cycle (the freed slot is the one written).
  always_comb begin
    do_pop    = pop && (count != 2'd0);
    do_push   = push && ((count != 2'd2) || do_pop);
    full      = (count == 2'd2);
    empty     = (count == 2'd0);
    head_data = mem[rd_ptr];
  end

  // Storage, pointers and occupancy.
  always_ff @(posedge usbclk) begin
    if (reset) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/tx_word_packer.sv
// USB transmit packer: registers FX2 writes, truncates over-long bursts,
// gathers RATIO narrow words into one wide word and queues it in a 2-entry
// output buffer. Truncations, partial-word drops and overflows are reported.
//
// Output handshake: a word transfers on any usbclk edge where out_valid and
// out_ready are both high. out_valid is a pure register decode (never a
// function of out_ready) and out_data holds steady while out_valid is high
// and out_ready is low.
module tx_word_packer
  import tx_pack_pkg::*;
#(
  parameter int IN_WIDTH  = 16,
  parameter int RATIO     = 2,
  parameter int OUT_WIDTH = IN_WIDTH * RATIO,
  parameter int BURST_MAX = 256,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                 usbclk,
  input  logic                 bus_reset,
  input  logic                 WR_fx2,
  input  logic [IN_WIDTH-1:0]  usbdata,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 trunc_pulse,
  output logic                 partial_pulse,
  output logic                 overflow_pulse,
  output logic [7:0]           overflow_count
);

  localparam int CNT_W  = clog2(BURST_MAX) + 1;
  localparam int LANE_W = lane_bits(RATIO);

  if (!ratio_legal(RATIO)) begin : g_bad_ratio
    $error("tx_word_packer: RATIO must lie within 2..8");
  end

  logic                 wr_q;
  logic [IN_WIDTH-1:0]  data_q;
  logic                 wr_prev;
  logic [CNT_W-1:0]     burst_cnt;
  logic                 trunc_seen;
  logic [LANE_W-1:0]    lane;
  logic [LANE_W-1:0]    lane_idx;
  logic [OUT_WIDTH-1:0] acc;
  logic [OUT_WIDTH-1:0] merged;
  logic                 accept;
  logic                 falling;
  logic                 complete;
  logic                 pop;
  logic                 drop;
  logic                 fifo_full;
  logic                 fifo_empty;
  pack_events_t         events_q;

  // Acceptance, completion and overflow decisions for the registered word.
  always_comb begin
    accept   = wr_q && (burst_cnt < CNT_W'(BURST_MAX));
    falling  = wr_prev && !wr_q;
    complete = accept && (lane == LANE_W'(RATIO - 1));
    lane_idx = LANE_W'(lane_index(int'(lane), RATIO, MSB_FIRST));
    pop      = out_valid && out_ready;
    drop     = complete && fifo_full && !pop;
  end

  // Accumulator image with the incoming word dropped into its lane.
  always_comb begin
    merged = acc;
    merged[int'(lane_idx) * IN_WIDTH +: IN_WIDTH] = data_q;
  end

  // Input registers and the burst limiter.
  always_ff @(posedge usbclk) begin
    if (bus_reset) begin
      wr_q       <= 1'b0;
      data_q     <= '0;
      wr_prev    <= 1'b0;
      burst_cnt  <= '0;
      trunc_seen <= 1'b0;
    end else begin
      wr_q    <= WR_fx2;
      data_q  <= usbdata;
      wr_prev <= wr_q;
      if (!wr_q) begin
        burst_cnt  <= '0;
        trunc_seen <= 1'b0;
      end else if (accept) begin
        burst_cnt <= burst_cnt + CNT_W'(1);
      end else begin
        trunc_seen <= 1'b1;
      end
    end
  end

  // Lane counter and accumulator; only a falling strobe abandons a partial word.
  always_ff @(posedge usbclk) begin
    if (bus_reset) begin
      lane <= '0;
      acc  <= '0;
    end else if (falling && (lane != '0)) begin
      lane <= '0;
    end else if (accept) begin
      acc  <= merged;
      lane <= complete ? '0 : lane + LANE_W'(1);
    end
  end

  // Registered status pulses and the saturating overflow counter.
  always_ff @(posedge usbclk) begin
    if (bus_reset) begin
      events_q       <= '0;
      overflow_count <= 8'd0;
    end else begin
      events_q.trunc    <= wr_q && !accept && !trunc_seen;
      events_q.partial  <= falling && (lane != '0);
      events_q.overflow <= drop;
      if (drop && (overflow_count != 8'hFF)) overflow_count <= overflow_count + 8'd1;
    end
  end

  tx_pack_fifo2 #(
    .WIDTH(OUT_WIDTH)
  ) u_fifo (
    .usbclk   (usbclk),
    .reset    (bus_reset),
    .push     (complete),
    .push_data(merged),
    .pop      (pop),
    .head_data(out_data),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign out_valid      = !fifo_empty;
  assign trunc_pulse    = events_q.trunc;
  assign partial_pulse  = events_q.partial;
  assign overflow_pulse = events_q.overflow;

endmodule

// File: tb/tb_tx_word_packer.sv
// Bench for tx_word_packer: two configurations (RATIO=2 LSB-first and
// RATIO=4 MSB-first) share one stimulus stream. Each has a burst/word-level
// reference model feeding an expected queue and a monitor that checks it.
module tb_tx_word_packer;

  localparam int IN_W = 16;
  localparam int BMAX = 256;

  logic            usbclk = 1'b0;
  logic            bus_reset;
  logic            WR_fx2;
  logic [IN_W-1:0] usbdata;
  logic            out_ready;

  int n_vec = 0;
  int n_err = 0;
  bit end_chk = 1'b0;

  // Clock.
  always #5 usbclk = ~usbclk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_cfg
    localparam int R  = (g == 0) ? 2 : 4;
    localparam bit M  = (g == 0) ? 1'b0 : 1'b1;
    localparam int OW = IN_W * R;

    logic [OW-1:0] out_data;
    logic          out_valid;
    logic          trunc_pulse;
    logic          partial_pulse;
    logic          overflow_pulse;
    logic [7:0]    overflow_count;

    tx_word_packer #(
      .IN_WIDTH (IN_W),
      .RATIO    (R),
      .BURST_MAX(BMAX),
      .MSB_FIRST(M)
    ) u_dut (
      .usbclk        (usbclk),
      .bus_reset     (bus_reset),
      .WR_fx2        (WR_fx2),
      .usbdata       (usbdata),
      .out_data      (out_data),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .trunc_pulse   (trunc_pulse),
      .partial_pulse (partial_pulse),
      .overflow_pulse(overflow_pulse),
      .overflow_count(overflow_count)
    );

    // Reference model state: words of the current group, words accepted in
    // the current burst, buffer occupancy and expected output words.
    logic [OW-1:0]   exp_q[$];
    logic [IN_W-1:0] words[$];
    int              m_burst = 0;
    int              m_cnt = 0;
    int              m_ovf = 0;
    bit              m_tseen = 1'b0;
    bit              m_fresh = 1'b0;
    bit              m_wr = 1'b0;
    logic [IN_W-1:0] m_data = '0;
    bit              e_trunc = 1'b0;
    bit              e_part = 1'b0;
    bit              e_ovf = 1'b0;
    bit              chk_done = 1'b0;

    function automatic logic [OW-1:0] pack_words();
      logic [OW-1:0] w;
      int pos;
      w = '0;
      for (int i = 0; i < R; i++) begin
        pos = M ? (R - 1 - i) : i;
        w[pos * IN_W +: IN_W] = words[i];
      end
      return w;
    endfunction

    // Model: one step per clock on the write seen one cycle earlier.
    always @(posedge usbclk) begin : model
      bit pop_now;
      bit got_word;
      logic [OW-1:0] w;
      e_trunc = 1'b0;
      e_part  = 1'b0;
      e_ovf   = 1'b0;
      w       = '0;
      if (bus_reset) begin
        exp_q.delete();
        words.delete();
        m_burst = 0;
        m_cnt   = 0;
        m_ovf   = 0;
        m_tseen = 1'b0;
        m_fresh = 1'b1;
        m_wr    = 1'b0;
        m_data  = '0;
      end else begin
        pop_now  = (m_cnt > 0) && out_ready;
        got_word = 1'b0;
        if (m_wr) begin
          if (m_burst < BMAX) begin
            m_burst++;
            words.push_back(m_data);
            if (words.size() == R) begin
              w = pack_words();
              words.delete();
              got_word = 1'b1;
            end
          end else if (!m_tseen) begin
            m_tseen = 1'b1;
            e_trunc = 1'b1;
          end
        end else begin
          m_burst = 0;
          m_tseen = 1'b0;
          if (words.size() != 0) begin
            e_part = 1'b1;
            words.delete();
          end
        end
        if (pop_now) m_cnt--;
        if (got_word) begin
          if (m_cnt < 2) begin
            m_cnt++;
            exp_q.push_back(w);
            m_fresh = 1'b0;
          end else begin
            e_ovf = 1'b1;
            if (m_ovf < 255) m_ovf++;
          end
        end
        m_wr   = WR_fx2;
        m_data = usbdata;
      end
    end

    // Monitor: compares DUT outputs against the model on the falling edge.
    always @(negedge usbclk) begin
      check($sformatf("cfg%0d out_valid", g), 64'(out_valid), 64'(m_cnt > 0));
      check($sformatf("cfg%0d trunc_pulse", g), 64'(trunc_pulse), 64'(e_trunc));
      check($sformatf("cfg%0d partial_pulse", g), 64'(partial_pulse), 64'(e_part));
      check($sformatf("cfg%0d overflow_pulse", g), 64'(overflow_pulse), 64'(e_ovf));
      check($sformatf("cfg%0d overflow_count", g), 64'(overflow_count), 64'(m_ovf));
      if (m_fresh) check($sformatf("cfg%0d out_data_reset", g), 64'(out_data), 64'd0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL cfg%0d out_data at %0t: got %h expected no word", g, $time, out_data);
        end else begin
          check($sformatf("cfg%0d out_data", g), 64'(out_data), 64'(exp_q.pop_front()));
        end
      end
      if (end_chk && !chk_done) begin
        chk_done = 1'b1;
        check($sformatf("cfg%0d words_left", g), 64'(exp_q.size()), 64'd0);
      end
    end
  end

  // Driver: apply one cycle of inputs, changing them just after the edge.
  task automatic drive(input bit w, input logic [IN_W-1:0] d, input bit r);
    WR_fx2    = w;
    usbdata   = d;
    out_ready = r;
    @(posedge usbclk);
    #1;
  endtask

  task automatic idle(input int n, input bit r);
    repeat (n) drive(1'b0, IN_W'($urandom), r);
  endtask

  task automatic do_reset(input int n);
    bus_reset = 1'b1;
    repeat (n) drive(1'b0, '0, 1'b1);
    bus_reset = 1'b0;
  endtask

  // Stimulus sequence and final report.
  initial begin
    logic [IN_W-1:0] basic [4];
    logic [IN_W-1:0] nib [4];
    basic = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    nib   = '{16'h000A, 16'h000B, 16'h000C, 16'h000D};
    bus_reset = 1'b1;
    WR_fx2    = 1'b0;
    usbdata   = '0;
    out_ready = 1'b1;
    do_reset(3);
    idle(2, 1'b1);

    // Basic packing and lane order.
    for (int i = 0; i < 4; i++) drive(1'b1, basic[i], 1'b1);
    idle(4, 1'b1);
    for (int i = 0; i < 4; i++) drive(1'b1, nib[i], 1'b1);
    idle(4, 1'b1);

    // Burst truncation with incrementing data.
    for (int i = 0; i < 260; i++) drive(1'b1, IN_W'(i + 1), 1'b1);
    idle(5, 1'b1);

    // Partial discard, then a fresh burst from lane 0.
    for (int i = 0; i < 3; i++) drive(1'b1, IN_W'(16'h0100 + i), 1'b1);
    idle(3, 1'b1);
    for (int i = 0; i < 4; i++) drive(1'b1, IN_W'(16'h0200 + i), 1'b1);
    idle(3, 1'b1);

    // Single-cycle write strobe.
    drive(1'b1, 16'hBEEF, 1'b1);
    idle(3, 1'b1);

    // Backpressure over six words, then release.
    for (int i = 0; i < 6; i++) drive(1'b1, IN_W'(16'h0300 + i), 1'b0);
    idle(4, 1'b0);
    idle(4, 1'b1);

    // Reset with one lane filled: nothing comes out.
    drive(1'b1, 16'h5555, 1'b1);
    drive(1'b1, 16'h6666, 1'b1);
    do_reset(2);
    idle(4, 1'b1);

    // Reset with buffered words discards them.
    for (int i = 0; i < 4; i++) drive(1'b1, IN_W'(16'h0700 + i), 1'b0);
    idle(2, 1'b0);
    do_reset(1);
    idle(3, 1'b1);

    // Randomized writes and backpressure.
    for (int i = 0; i < 900; i++)
      drive($urandom_range(0, 9) < 7, IN_W'($urandom), $urandom_range(0, 2) != 0);
    idle(6, 1'b1);

    // Long random burst crossing the limit under random backpressure.
    for (int i = 0; i < 300; i++)
      drive(1'b1, IN_W'($urandom), $urandom_range(0, 3) != 0);
    idle(30, 1'b1);

    end_chk = 1'b1;
    @(negedge usbclk);
    @(negedge usbclk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
